// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one cache-line memory port between the
// instruction-fetch path (I-cache miss reads) and the data path (D-cache
// miss reads and writebacks). One transaction at a time goes through a
// three-state FSM, and its response is steered back to the requester that
// owns it.
//
// A fetch flush cancels delivery of an instruction fill that is in flight.
// The memory side still finishes normally, but i_resp is never raised for
// that fill.
//
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to alternate between the
// two requesters when both are pending. Without it, the data path always
// wins a tie.
module mem_port_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              flush,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              drop;
    logic              i_req;
    logic              d_req;
    logic              grant_i;
    logic              grant_d;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Set when the data side should win the next tie. It comes out of reset
    // favouring data and flips toward whichever side was not just served.
    logic favour_d;

    assign grant_d = d_req && (!i_req || favour_d);
    assign grant_i = i_req && !grant_d;

    // Move the pointer on every grant, including grants where only one side was requesting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            favour_d <= 1'b1;
        end else if (state == IDLE && (grant_d || grant_i)) begin
            favour_d <= grant_i;
        end
    end
`else
    // Fixed priority: the data path always beats instruction fetch.
    assign grant_d = d_req;
    assign grant_i = i_req && !grant_d;
`endif

    // Main FSM. It grants a requester, latches that transaction, and holds the memory strobes until mem_resp.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            drop      <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state     <= D_BUSY;
                        addr_q    <= d_addr;
                        wdata_q   <= d_wdata;
                        mem_read  <= !d_write;
                        mem_write <= d_write;
                    end else if (grant_i) begin
                        state     <= I_BUSY;
                        addr_q    <= i_addr;
                        mem_read  <= 1'b1;
                        mem_write <= 1'b0;
                        drop      <= flush;
                    end
                end
                I_BUSY: begin
                    if (mem_resp) begin
                        state    <= IDLE;
                        mem_read <= 1'b0;
                        drop     <= 1'b0;
                    end else if (flush) begin
                        drop <= 1'b1;
                    end
                end
                D_BUSY: begin
                    if (mem_resp) begin
                        state     <= IDLE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    drop      <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // A flush that arrives in the same cycle as the memory response must
    // also suppress i_resp. That is why the live flush input is included
    // here along with the drop bit.
    assign i_resp  = (state == I_BUSY) && mem_resp && !drop && !flush;
    assign i_rdata = (state == I_BUSY) ? mem_rdata : '0;
    assign d_resp  = (state == D_BUSY) && mem_resp;
    assign d_rdata = (state == D_BUSY) ? mem_rdata : '0;

endmodule
